// File: rtl/tcp_tx_segmenter.sv
// tcp_tx_segmenter
//   Application-side TX front end for the TCP wrapper. Takes one send request
//   (session, total bytes) and its 512-bit payload stream, then cuts it into
//   segments of at most MAX_SEG bytes. For each segment it issues TX metadata,
//   waits for the stack's TX status, and then forwards, retries after a
//   back-off, or aborts and drains the rest. One completion per request.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   s_req_*                       send request {total_bytes[47:16], session[15:0]}
//   s_data_*                      payload in, 64 bytes per beat
//   m_meta_*                      TX metadata to the stack {16'h0, len, session}
//   s_status_*                    TX status from the stack {err, space, len, session}
//   m_data_*                      segmented payload out, last marks segment end
//   m_done_*                      completion {14'h0, code, session}
//   seg_cnt, retry_cnt, err_cnt   free-running statistics, wrap at 2^32
module tcp_tx_segmenter #(
  parameter int unsigned MAX_SEG        = 1024,
  parameter int unsigned RETRY_GAP      = 256,
  parameter logic [31:0] TIME_OUT_CYCLE = 32'hDF84_7580
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_req_valid,
  output logic         s_req_ready,
  input  logic [47:0]  s_req_data,
  input  logic         s_data_valid,
  output logic         s_data_ready,
  input  logic [511:0] s_data_data,
  input  logic [63:0]  s_data_keep,
  input  logic         s_data_last,
  output logic         m_meta_valid,
  input  logic         m_meta_ready,
  output logic [47:0]  m_meta_data,
  input  logic         s_status_valid,
  output logic         s_status_ready,
  input  logic [63:0]  s_status_data,
  output logic         m_data_valid,
  input  logic         m_data_ready,
  output logic [511:0] m_data_data,
  output logic [63:0]  m_data_keep,
  output logic         m_data_last,
  output logic         m_done_valid,
  input  logic         m_done_ready,
  output logic [31:0]  m_done_data,
  output logic [31:0]  seg_cnt,
  output logic [31:0]  retry_cnt,
  output logic [31:0]  err_cnt
);

  typedef enum logic [2:0] {
    IDLE, META, WAIT_STATUS, DATA, BACKOFF, DRAIN, DONE
  } state_t;

  state_t      state, nxt;
  logic [15:0] session;
  logic [31:0] rem;
  logic [1:0]  done_code, abort_code;
  logic [10:0] beat_cnt;
  logic [26:0] drain_cnt;
  logic [31:0] to_cnt, bo_cnt;

  // Segment geometry follows rem, which only moves at a segment's last beat,
  // so metadata stays stable for the whole META hold.
  logic [15:0] seg_len;
  logic [10:0] seg_beats;
  logic [26:0] drain_beats;
  assign seg_len     = (rem < 32'(MAX_SEG)) ? rem[15:0] : 16'(MAX_SEG);
  assign seg_beats   = 11'((17'(seg_len) + 17'd63) >> 6);
  assign drain_beats = 27'((33'(rem) + 33'd63) >> 6);

  logic [1:0] st_err;
  logic       st_sess_ok;
  assign st_err     = s_status_data[63:62];
  assign st_sess_ok = (s_status_data[15:0] == session);

  logic req_fire, meta_fire, st_fire, out_fire, drain_fire, done_fire, seg_end;
  assign req_fire   = s_req_valid & s_req_ready;
  assign meta_fire  = m_meta_valid & m_meta_ready;
  assign st_fire    = s_status_valid & s_status_ready;
  assign out_fire   = m_data_valid & m_data_ready;
  assign drain_fire = (state == DRAIN) & s_data_valid;
  assign done_fire  = m_done_valid & m_done_ready;
  assign seg_end    = out_fire & (beat_cnt == seg_beats - 11'd1);

  // Payload path is a straight pass-through in DATA; framing comes from the
  // beat counter, the upstream last flag plays no part.
  assign m_data_valid = (state == DATA) & s_data_valid;
  assign s_data_ready = (state == DATA) ? m_data_ready : (state == DRAIN);
  assign m_data_data  = (state == DATA) ? s_data_data : '0;
  assign m_data_keep  = (state == DATA) ? s_data_keep : '0;
  assign m_data_last  = (state == DATA) & (beat_cnt == seg_beats - 11'd1);
  assign m_meta_data  = {16'h0, seg_len, session};
  assign m_done_data  = {14'h0, done_code, session};

  logic unused_ok;
  assign unused_ok = ^{s_status_data[61:16], s_data_last};

  always_comb begin
    nxt        = state;
    abort_code = 2'd3;
    case (state)
      IDLE:        if (req_fire) nxt = (s_req_data[47:16] == 32'd0) ? DONE : META;
      META:        if (meta_fire) nxt = WAIT_STATUS;
      WAIT_STATUS: begin
        if (st_fire) begin
          if (!st_sess_ok)          nxt = DRAIN;
          else if (st_err == 2'd0)  nxt = DATA;
          else if (st_err == 2'd1)  nxt = BACKOFF;
          else begin
            nxt        = DRAIN;
            abort_code = 2'd2;
          end
        end else if (to_cnt == TIME_OUT_CYCLE - 32'd1) begin
          nxt = DRAIN;
        end
      end
      BACKOFF:     if (bo_cnt == 32'(RETRY_GAP) - 32'd1) nxt = META;
      DATA:        if (seg_end) nxt = (rem == 32'(seg_len)) ? DONE : META;
      DRAIN:       if (drain_fire && drain_cnt == drain_beats - 27'd1) nxt = DONE;
      DONE:        if (done_fire) nxt = IDLE;
      default:     nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state, so they are all
  // low during and right after reset and rise one cycle later in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      s_req_ready    <= 1'b0;
      m_meta_valid   <= 1'b0;
      s_status_ready <= 1'b0;
      m_done_valid   <= 1'b0;
      session        <= '0;
      rem            <= '0;
      done_code      <= '0;
      beat_cnt       <= '0;
      drain_cnt      <= '0;
      to_cnt         <= '0;
      bo_cnt         <= '0;
      seg_cnt        <= '0;
      retry_cnt      <= '0;
      err_cnt        <= '0;
    end else begin
      state          <= nxt;
      s_req_ready    <= (nxt == IDLE);
      m_meta_valid   <= (nxt == META);
      s_status_ready <= (nxt == WAIT_STATUS);
      m_done_valid   <= (nxt == DONE);

      // Per-state counters restart whenever their state is left.
      beat_cnt  <= (state == DATA)        ? beat_cnt + 11'(out_fire)    : '0;
      drain_cnt <= (state == DRAIN)       ? drain_cnt + 27'(drain_fire) : '0;
      to_cnt    <= (state == WAIT_STATUS) ? to_cnt + 32'd1              : '0;
      bo_cnt    <= (state == BACKOFF)     ? bo_cnt + 32'd1              : '0;

      if (req_fire) begin
        session   <= s_req_data[15:0];
        rem       <= s_req_data[47:16];
        done_code <= 2'd0;
      end
      if (seg_end) begin
        rem     <= rem - 32'(seg_len);
        seg_cnt <= seg_cnt + 32'd1;
      end
      if (st_fire && st_sess_ok && st_err == 2'd1)
        retry_cnt <= retry_cnt + 32'd1;
      if (state == WAIT_STATUS && nxt == DRAIN) begin
        err_cnt   <= err_cnt + 32'd1;
        done_code <= abort_code;
      end
    end
  end

endmodule

// File: tb/tb_tcp_tx_segmenter.sv
// Directed bench for tcp_tx_segmenter with a scoreboard of expected metadata,
// payload beats and completions; a small stack model answers each metadata
// handshake with a planned status code.
module tb_tcp_tx_segmenter;
  localparam int MAX_SEG = 1024;
  localparam int RETRY_GAP = 256;

  logic         clk, rst;
  logic         s_req_valid, s_req_ready;
  logic [47:0]  s_req_data;
  logic         s_data_valid, s_data_ready, s_data_last;
  logic [511:0] s_data_data;
  logic [63:0]  s_data_keep;
  logic         m_meta_valid, m_meta_ready;
  logic [47:0]  m_meta_data;
  logic         s_status_valid, s_status_ready;
  logic [63:0]  s_status_data;
  logic         m_data_valid, m_data_ready, m_data_last;
  logic [511:0] m_data_data;
  logic [63:0]  m_data_keep;
  logic         m_done_valid, m_done_ready;
  logic [31:0]  m_done_data, seg_cnt, retry_cnt, err_cnt;

  tcp_tx_segmenter #(.MAX_SEG(MAX_SEG), .RETRY_GAP(RETRY_GAP), .TIME_OUT_CYCLE(32'd100)) dut (
    .clk(clk), .rst(rst),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_data(s_req_data),
    .s_data_valid(s_data_valid), .s_data_ready(s_data_ready), .s_data_data(s_data_data),
    .s_data_keep(s_data_keep), .s_data_last(s_data_last),
    .m_meta_valid(m_meta_valid), .m_meta_ready(m_meta_ready), .m_meta_data(m_meta_data),
    .s_status_valid(s_status_valid), .s_status_ready(s_status_ready), .s_status_data(s_status_data),
    .m_data_valid(m_data_valid), .m_data_ready(m_data_ready), .m_data_data(m_data_data),
    .m_data_keep(m_data_keep), .m_data_last(m_data_last),
    .m_done_valid(m_done_valid), .m_done_ready(m_done_ready), .m_done_data(m_done_data),
    .seg_cnt(seg_cnt), .retry_cnt(retry_cnt), .err_cnt(err_cnt)
  );

  typedef struct packed { logic [511:0] data; logic [63:0] keep; logic last; } beat_t;
  beat_t       exp_beats[$];
  logic [47:0] exp_meta[$];
  logic [31:0] exp_done[$];
  int          st_plan[$];
  logic [63:0] st_pend[$];

  int checks = 0, errors = 0, cyc = 0;
  int st1_cyc = 0, meta_rise_cyc = 0, meta_hs_cyc = 0, drdy_rise_cyc = 0;
  int req_hs_cyc = 0, done_rise_cyc = 0;
  logic prev_meta_v = 0, prev_drdy = 0, prev_done_v = 0;
  bit bp_en = 0, abort_tx = 0;

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end
  initial begin #1000000; $display("FAIL watchdog expired at cycle %0d", cyc); $fatal(1, "watchdog"); end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk512(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pat(input logic [15:0] tag, input int i);
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = {tag, 16'(i*16 + w)};
    return d;
  endfunction

  function automatic logic [63:0] kfn(input int nbytes);
    logic [63:0] one = 64'd1;
    return (nbytes >= 64) ? '1 : ((one << nbytes) - 64'd1);
  endfunction

  // Expected output for the first nfwd input beats of a request.
  task automatic push_exp(input logic [15:0] tag, input int bytes, input int nfwd);
    int nb = (bytes + 63) / 64;
    for (int i = 0; i < nfwd; i++) begin
      beat_t b;
      b.data = pat(tag, i);
      b.keep = (i == nb - 1) ? kfn(bytes - 64*i) : '1;
      b.last = ((i + 1) % (MAX_SEG/64) == 0) || (i == nb - 1);
      exp_beats.push_back(b);
    end
  endtask

  task automatic drive_req(input logic [15:0] sess, input logic [31:0] bytes);
    int n = 0;
    @(posedge clk); #1;
    s_req_valid = 1; s_req_data = {bytes, sess};
    do begin @(negedge clk); n++; end while (!s_req_ready && n < 5000);
    chk("req_accept", 64'(s_req_ready), 64'd1);
    req_hs_cyc = cyc;
    @(posedge clk); #1;
    s_req_valid = 0;
  endtask

  task automatic send_beats(input logic [15:0] tag, input int bytes);
    int nb = (bytes + 63) / 64;
    int n;
    @(posedge clk); #1;
    for (int i = 0; i < nb; i++) begin
      if (abort_tx) break;
      s_data_data = pat(tag, i);
      s_data_keep = (i == nb - 1) ? kfn(bytes - 64*i) : '1;
      s_data_last = (i == nb - 1);
      s_data_valid = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!s_data_ready && !abort_tx && n < 3000);
      if (abort_tx) break;
      if (!s_data_ready) begin chk("data_in_tmo", 64'd0, 64'd1); break; end
      @(posedge clk); #1;
    end
    s_data_valid = 0; s_data_last = 0;
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while ((exp_beats.size() > 0 || exp_meta.size() > 0 || exp_done.size() > 0) && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_complete"}, 64'(n < 5000), 64'd1);
    @(posedge clk); #1;
  endtask

  // Output monitor / scoreboard, sampled mid-cycle.
  initial forever begin
    beat_t b;
    int e;
    @(negedge clk);
    if (!rst) begin
      if (m_data_valid && m_data_ready) begin
        if (exp_beats.size() == 0) chk("unexp_beat", 64'd1, 64'd0);
        else begin
          b = exp_beats.pop_front();
          chk512("beat_data", m_data_data, b.data);
          chk("beat_keep", m_data_keep, b.keep);
          chk("beat_last", 64'(m_data_last), 64'(b.last));
        end
      end
      if (m_meta_valid && m_meta_ready) begin
        if (exp_meta.size() == 0) chk("unexp_meta", 64'd1, 64'd0);
        else chk("meta", 64'(m_meta_data), 64'(exp_meta.pop_front()));
        meta_hs_cyc = cyc + 1;
        e = (st_plan.size() > 0) ? st_plan.pop_front() : 0;
        if (e >= 0) st_pend.push_back({2'(e), 30'h0, m_meta_data[31:0]});
      end
      if (s_status_valid && s_status_ready && s_status_data[63:62] == 2'd1) st1_cyc = cyc + 1;
      if (m_done_valid && m_done_ready) begin
        if (exp_done.size() == 0) chk("unexp_done", 64'd1, 64'd0);
        else chk("done", 64'(m_done_data), 64'(exp_done.pop_front()));
      end
      if (m_meta_valid && !prev_meta_v) meta_rise_cyc = cyc;
      if (s_data_ready && !prev_drdy) drdy_rise_cyc = cyc;
      if (m_done_valid && !prev_done_v) done_rise_cyc = cyc;
    end
    prev_meta_v = m_meta_valid; prev_drdy = s_data_ready; prev_done_v = m_done_valid;
  end

  // Stack model: answers each pending metadata with its planned status.
  initial begin
    int n;
    s_status_valid = 0; s_status_data = '0;
    forever begin
      @(posedge clk); #1;
      if (st_pend.size() > 0 && !rst) begin
        s_status_data = st_pend.pop_front();
        s_status_valid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_status_ready && !rst && n < 2000);
        if (!s_status_ready && !rst) chk("status_tmo", 64'd0, 64'd1);
        @(posedge clk); #1;
        s_status_valid = 0;
      end
    end
  end

  initial begin
    m_meta_ready = 0; m_data_ready = 0; m_done_ready = 0;
    forever begin
      @(posedge clk); #1;
      m_meta_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      m_data_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      m_done_ready = 1'b1;
    end
  end

  initial begin
    rst = 1;
    s_req_valid = 0; s_req_data = '0;
    s_data_valid = 0; s_data_data = '0; s_data_keep = '0; s_data_last = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 64'({s_req_ready, s_data_ready, m_meta_valid, s_status_ready,
                         m_data_valid, m_done_valid, m_data_last}), 64'd0);
    chk("rst_cnt", 64'(seg_cnt | retry_cnt | err_cnt), 64'd0);
    chk512("rst_data", m_data_data, '0);
    chk("rst_meta_done", 64'(m_meta_data) | 64'(m_done_data) | m_data_keep, 64'd0);
    @(posedge clk); #1; rst = 0;
    repeat (2) @(posedge clk);

    // 1: 2500 B in three segments.
    push_exp(16'h5, 2500, 40);
    exp_meta.push_back({16'h0, 16'd1024, 16'h5});
    exp_meta.push_back({16'h0, 16'd1024, 16'h5});
    exp_meta.push_back({16'h0, 16'd452, 16'h5});
    exp_done.push_back({14'h0, 2'd0, 16'h5});
    fork drive_req(16'h5, 32'd2500); send_beats(16'h5, 2500); join
    wait_empty("t1");
    chk("t1_seg_cnt", 64'(seg_cnt), 64'd3);

    // 2: no-buffer retry then success.
    st_plan.push_back(1); st_plan.push_back(0);
    exp_meta.push_back({16'h0, 16'd200, 16'h7});
    exp_meta.push_back({16'h0, 16'd200, 16'h7});
    push_exp(16'h7, 200, 4);
    exp_done.push_back({14'h0, 2'd0, 16'h7});
    fork drive_req(16'h7, 32'd200); send_beats(16'h7, 200); join
    wait_empty("t2");
    chk("t2_backoff_gap", 64'(meta_rise_cyc - st1_cyc), 64'(RETRY_GAP));
    chk("t2_retry_cnt", 64'(retry_cnt), 64'd1);
    chk("t2_seg_cnt", 64'(seg_cnt), 64'd4);

    // 3: stack error on segment 2 of 3000 B; rest drained.
    st_plan.push_back(0); st_plan.push_back(2);
    exp_meta.push_back({16'h0, 16'd1024, 16'h9});
    exp_meta.push_back({16'h0, 16'd1024, 16'h9});
    push_exp(16'h9, 3000, 16);
    exp_done.push_back({14'h0, 2'd2, 16'h9});
    fork drive_req(16'h9, 32'd3000); send_beats(16'h9, 3000); join
    wait_empty("t3");
    chk("t3_err_cnt", 64'(err_cnt), 64'd1);
    chk("t3_seg_cnt", 64'(seg_cnt), 64'd5);

    // 4: status never arrives.
    st_plan.push_back(-1);
    exp_meta.push_back({16'h0, 16'd100, 16'hA});
    exp_done.push_back({14'h0, 2'd3, 16'hA});
    fork drive_req(16'hA, 32'd100); send_beats(16'hA, 100); join
    wait_empty("t4");
    chk("t4_timeout_cycles", 64'(drdy_rise_cyc - meta_hs_cyc), 64'd100);
    chk("t4_err_cnt", 64'(err_cnt), 64'd2);

    // 5: zero-length request.
    exp_done.push_back({14'h0, 2'd0, 16'h3});
    drive_req(16'h3, 32'd0);
    wait_empty("t5");
    chk("t5_done_latency", 64'(done_rise_cyc - req_hs_cyc), 64'd1);

    // 6: random backpressure, reset in the middle of segment 2.
    bp_en = 1;
    push_exp(16'h11, 2500, 40);
    exp_meta.push_back({16'h0, 16'd1024, 16'h11});
    exp_meta.push_back({16'h0, 16'd1024, 16'h11});
    exp_meta.push_back({16'h0, 16'd452, 16'h11});
    exp_done.push_back({14'h0, 2'd0, 16'h11});
    fork
      drive_req(16'h11, 32'd2500);
      send_beats(16'h11, 2500);
      begin : watch
        int n;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (exp_beats.size() > 20 && n < 5000);
        chk("t6_reached_mid", 64'(exp_beats.size()), 64'd20);
        rst = 1; abort_tx = 1;
        #1;
        chk("t6_rst_ctrl", 64'({s_req_ready, s_data_ready, m_meta_valid, s_status_ready,
                                m_data_valid, m_done_valid, m_data_last}), 64'd0);
        chk("t6_rst_cnt", 64'(seg_cnt | retry_cnt | err_cnt), 64'd0);
        chk512("t6_rst_data", m_data_data, '0);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    exp_beats.delete(); exp_meta.delete(); exp_done.delete();
    st_plan.delete(); st_pend.delete();
    bp_en = 0; abort_tx = 0; rst = 0;
    repeat (2) @(posedge clk);

    // 7: normal request after the reset.
    exp_meta.push_back({16'h0, 16'd300, 16'h22});
    push_exp(16'h22, 300, 5);
    exp_done.push_back({14'h0, 2'd0, 16'h22});
    fork drive_req(16'h22, 32'd300); send_beats(16'h22, 300); join
    wait_empty("t7");
    chk("t7_seg_cnt", 64'(seg_cnt), 64'd1);
    chk("t7_err_retry", 64'({err_cnt, retry_cnt}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcp_tx_segmenter.md
Name: tcp_tx_segmenter

Overview:
- Application-side TX front end that feeds the TCP wrapper's TX metadata, data and status channels. It runs in the same clock domain as the application.
- Accepts one send request (session, total byte count) plus the matching 512-bit payload stream, and splits it into segments of at most MAX_SEG bytes.
- For each segment it issues TX metadata and waits for the stack's TX status. On success it forwards that segment's payload; on "no buffer space" it backs off and retries; on any other error it aborts and drains the rest of the request.
- Reports one completion per request.

Parameters:
- MAX_SEG, 1024, maximum segment length in bytes; must be a multiple of 64 and no more than 65472.
- RETRY_GAP, 256, idle cycles in BACKOFF before metadata is re-issued.
- TIME_OUT_CYCLE, 32'hDF84_7580, cycles allowed in WAIT_STATUS before the request is aborted.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- s_req_valid / s_req_ready  in / out  1 / 1  send-request handshake.
- s_req_data  in  48  [15:0] session id, [47:16] total bytes.
- s_data_valid / s_data_ready  in / out  1 / 1  payload handshake.
- s_data_data / s_data_keep / s_data_last  in  512 / 64 / 1  payload; 64 bytes per beat; keep is all-ones except on the request's final beat.
- m_meta_valid / m_meta_ready  out / in  1 / 1  TX metadata handshake to the stack.
- m_meta_data  out  48  [15:0] session, [31:16] segment length in bytes, [47:32] zero.
- s_status_valid / s_status_ready  in / out  1 / 1  TX status handshake from the stack.
- s_status_data  in  64  [15:0] session, [31:16] length, [61:32] space, [63:62] error code.
- m_data_valid / m_data_ready  out / in  1 / 1  segmented payload handshake to the stack.
- m_data_data / m_data_keep / m_data_last  out  512 / 64 / 1  segmented payload; last marks the end of each segment.
- m_done_valid / m_done_ready  out / in  1 / 1  completion handshake.
- m_done_data  out  32  [15:0] session, [17:16] code (0 ok, 2 stack error, 3 timeout/mismatch), rest zero.
- seg_cnt / retry_cnt / err_cnt  out  32 each  free-running statistics counters.

Behaviour:
- Reset: state IDLE. All valid outputs 0. All ready outputs 0. All counters 0. Data outputs 0.
- Reset mid-request abandons the request immediately; no done is emitted.
- States: IDLE, META, WAIT_STATUS, DATA, BACKOFF, DRAIN, DONE.
- IDLE:
  - s_req_ready=1; accepting a request latches session and remaining bytes (rem).
  - rem==0 goes directly to DONE with code 0.
  - Otherwise go to META.
- META:
  - seg_len = min(rem, MAX_SEG); beats = ceil(seg_len/64).
  - m_meta_valid=1 with data held stable until m_meta_ready.
  - After the handshake go to WAIT_STATUS, clear the timeout counter.
- WAIT_STATUS:
  - s_status_ready=1.
  - On handshake with error==0 and session matching: go to DATA.
  - error==1: retry_cnt++, go to BACKOFF.
  - error==2 or 3: code 2, go to DRAIN.
  - Session mismatch: code 3, go to DRAIN.
  - Timeout counter reaching TIME_OUT_CYCLE: code 3, go to DRAIN.
  - Every abort path increments err_cnt.
- BACKOFF: count RETRY_GAP cycles, then return to META with the same segment.
- DATA:
  - Combinational pass-through: m_data_valid=s_data_valid, s_data_ready=m_data_ready, data and keep copied unchanged.
  - m_data_last=1 on beat index beats-1; s_data_last is ignored for framing.
  - On the last beat's handshake: seg_cnt++, rem -= seg_len.
  - If rem==0 go to DONE with code 0, else go to META.
- DRAIN:
  - s_data_ready=1, m_data_valid=0.
  - Discard ceil(rem/64) beats, then go to DONE.
- DONE: m_done_valid=1 until handshake, then go to IDLE.
- Only one request is outstanding; s_req_ready=0 outside IDLE.
- Counters are 32-bit and wrap modulo 2^32.
- s_status_valid outside WAIT_STATUS is not accepted (ready=0).

Test Plan:
- Request session 0x0005, 2500 B, MAX_SEG=1024 -> metadata lengths 1024, 1024, 452; beats 16/16/8 with last on beat 15/15/7; final keep = 2^4-1 (452 = 7×64 + 4); done {code 0, session 5}; seg_cnt=3.
- First status error=1, second error=0 -> exactly RETRY_GAP idle cycles, metadata re-issued identically, retry_cnt=1, payload forwarded once.
- Status error=2 on segment 2 of a 3000 B request -> remaining 1976 B (31 beats) drained, no output beats after segment 1, done code 2, err_cnt=1.
- No status with TIME_OUT_CYCLE=100 -> done code 3 at cycle 100 after the metadata handshake; all input beats drained.
- Request length 0 -> no metadata, done code 0 one cycle after the request is accepted.
- Random m_data_ready/m_meta_ready backpressure plus rst asserted mid-DATA -> no beat lost or duplicated before reset; all outputs 0 immediately on rst; the next request proceeds normally.
